// File: rtl/execute_state_sequencer_pkg.sv
// Shared encodings for the PIC16C5x execute sequencer and the write-control
// blocks that consume its Q4 state.
package execute_state_sequencer_pkg;

    localparam int INST_WIDTH    = 12;
    localparam int EX_STATE_BITS = 5;

    // Execute-phase state. Q4 states name the instruction class being
    // retired, so the W/GPR/PC/STATUS write controls can key directly off it.
    typedef enum logic [EX_STATE_BITS-1:0] {
        EX_Q1        = 5'd0,
        EX_Q2        = 5'd1,
        EX_Q3        = 5'd2,
        EX_Q4_CLRF   = 5'd3,
        EX_Q4_CLRW   = 5'd4,
        EX_Q4_FSZ    = 5'd5,
        EX_Q4_MOVF   = 5'd6,
        EX_Q4_MOVWF  = 5'd7,
        EX_Q4_BXF    = 5'd8,
        EX_Q4_BTFSX  = 5'd9,
        EX_Q4_RETLW  = 5'd10,
        EX_Q4_CALL   = 5'd11,
        EX_Q4_GOTO   = 5'd12,
        EX_Q4_MOVLW  = 5'd13,
        EX_Q4_ALUXLW = 5'd14,
        EX_Q4_ELSE   = 5'd15,
        EX_Q4_OPTION = 5'd16,
        EX_Q4_SLEEP  = 5'd17,
        EX_Q4_CLRWDT = 5'd18,
        EX_Q4_TRIS   = 5'd19,
        EX_Q4_NOP    = 5'd20,
        EX_HALT      = 5'd21
    } exState_t;

    // Low five bits of the 0000_0000_0xxx special-instruction group.
    localparam logic [4:0] SPC_NOP    = 5'd0;
    localparam logic [4:0] SPC_OPTION = 5'd2;
    localparam logic [4:0] SPC_SLEEP  = 5'd3;
    localparam logic [4:0] SPC_CLRWDT = 5'd4;

    // True for any of the Q4 instruction-retire states.
    function automatic logic isQ4(input exState_t s);
        return (s >= EX_Q4_CLRF) && (s <= EX_Q4_NOP);
    endfunction

    // Program-flow changes: the PC block loads a target instead of incrementing,
    // and the already-fetched next word must be discarded.
    function automatic logic isTransfer(input exState_t s);
        return (s == EX_Q4_GOTO) || (s == EX_Q4_CALL) || (s == EX_Q4_RETLW);
    endfunction

    // Conditional skips: the next word is discarded only when the condition holds.
    function automatic logic isSkip(input exState_t s);
        return (s == EX_Q4_FSZ) || (s == EX_Q4_BTFSX);
    endfunction

    // Flush value for the instruction following the one retiring in Q4.
    // A flushed instruction retires as EX_Q4_NOP, so flushes never chain.
    function automatic logic nextFlush(input exState_t s, input logic skip);
        if (isTransfer(s)) begin
            return 1'b1;
        end
        if (isSkip(s)) begin
            return skip;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/execute_state_sequencer_q4_decode.sv
// Combinational decode of the 12-bit instruction word into the Q4 retire
// state. The W, GPR and PC write controls share this encoding.
module inst_q4_decode
    import execute_state_sequencer_pkg::*;
(
    input  logic [INST_WIDTH-1:0]    ir,
    output logic [EX_STATE_BITS-1:0] q4State
);

    exState_t q4;

    // Classify the instruction by its upper six bits, refining the
    // 0000_00 / 0000_01 groups with the low bits.
    always_comb begin
        q4 = EX_Q4_NOP;
        casez (ir[11:6])
            6'b000000: begin
                if (ir[5]) begin
                    q4 = EX_Q4_MOVWF;
                end else begin
                    case (ir[4:0])
                        SPC_NOP:    q4 = EX_Q4_NOP;
                        SPC_OPTION: q4 = EX_Q4_OPTION;
                        SPC_SLEEP:  q4 = EX_Q4_SLEEP;
                        SPC_CLRWDT: q4 = EX_Q4_CLRWDT;
                        5'd5, 5'd6, 5'd7: q4 = EX_Q4_TRIS;
                        default:    q4 = EX_Q4_NOP;
                    endcase
                end
            end
            6'b000001: begin
                if (ir[5]) begin
                    q4 = EX_Q4_CLRF;
                end else if (ir[4:0] == 5'd0) begin
                    q4 = EX_Q4_CLRW;
                end else begin
                    q4 = EX_Q4_NOP;
                end
            end
            6'b00001?, 6'b0001??: q4 = EX_Q4_ELSE;
            6'b001000:            q4 = EX_Q4_MOVF;
            6'b001011, 6'b001111: q4 = EX_Q4_FSZ;
            6'b001001, 6'b001010,
            6'b001100, 6'b001101,
            6'b001110:            q4 = EX_Q4_ELSE;
            6'b010???:            q4 = EX_Q4_BXF;
            6'b011???:            q4 = EX_Q4_BTFSX;
            6'b1000??:            q4 = EX_Q4_RETLW;
            6'b1001??:            q4 = EX_Q4_CALL;
            6'b101???:            q4 = EX_Q4_GOTO;
            6'b1100??:            q4 = EX_Q4_MOVLW;
            6'b1101??, 6'b111???: q4 = EX_Q4_ALUXLW;
            default:              q4 = EX_Q4_NOP;
        endcase
    end

    assign q4State = q4;

endmodule

// File: rtl/execute_state_sequencer.sv
// Execute-phase sequencer: runs the Q1..Q4 cycle, selects the Q4 retire
// state, tracks pipeline flushes and handles SLEEP halt / wake.
module execute_state_sequencer
    import execute_state_sequencer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INST_WIDTH-1:0]    IR,
    input  logic                     skipCond,
    input  logic                     wake,
    output logic [EX_STATE_BITS-1:0] executeState,
    output logic                     irLoad,
    output logic                     pcInc,
    output logic                     flushed,
    output logic                     sleeping
);

    exState_t                 state;
    logic                     flush;
    logic [EX_STATE_BITS-1:0] decodedBits;
    exState_t                 decodedState;
    exState_t                 q4Sel;

    inst_q4_decode uDecode (
        .ir      (IR),
        .q4State (decodedBits)
    );

    assign decodedState = exState_t'(decodedBits);

    // A flushed instruction retires as NOP regardless of what IR holds.
    assign q4Sel = flush ? EX_Q4_NOP : decodedState;

    // Phase/halt state machine with registered strobes; flush only moves at
    // the Q4->Q1 edge (or on wake), so it is stable across a whole instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EX_Q1;
            flush    <= 1'b1;
            sleeping <= 1'b0;
            irLoad   <= 1'b0;
            pcInc    <= 1'b0;
        end else begin
            case (state)
                EX_Q1: state <= EX_Q2;
                EX_Q2: state <= EX_Q3;
                EX_Q3: begin
                    state  <= q4Sel;
                    irLoad <= 1'b1;
                    pcInc  <= !isTransfer(q4Sel);
                end
                EX_HALT: begin
                    if (wake) begin
                        state    <= EX_Q1;
                        flush    <= 1'b0;
                        sleeping <= 1'b0;
                    end
                end
                default: begin
                    irLoad <= 1'b0;
                    pcInc  <= 1'b0;
                    if (state == EX_Q4_SLEEP) begin
                        state    <= EX_HALT;
                        sleeping <= 1'b1;
                        flush    <= 1'b0;
                    end else if (isQ4(state)) begin
                        state <= EX_Q1;
                        flush <= nextFlush(state, skipCond);
                    end else begin
                        // Unused encodings recover to a clean instruction start.
                        state <= EX_Q1;
                    end
                end
            endcase
        end
    end

    assign executeState = state;
    assign flushed      = flush;

endmodule

// File: tb/tb_execute_state_sequencer.sv
// Directed bench for execute_state_sequencer plus a full sweep of the
// inst_q4_decode instruction classifier.
module tb_execute_state_sequencer;

    localparam logic [4:0] S_Q1 = 5'd0,  S_Q2 = 5'd1,  S_Q3 = 5'd2;
    localparam logic [4:0] S_CLRF = 5'd3, S_CLRW = 5'd4, S_FSZ = 5'd5, S_MOVF = 5'd6;
    localparam logic [4:0] S_MOVWF = 5'd7, S_BXF = 5'd8, S_BTFSX = 5'd9, S_RETLW = 5'd10;
    localparam logic [4:0] S_CALL = 5'd11, S_GOTO = 5'd12, S_MOVLW = 5'd13, S_ALUXLW = 5'd14;
    localparam logic [4:0] S_ELSE = 5'd15, S_OPTION = 5'd16, S_SLEEP = 5'd17, S_CLRWDT = 5'd18;
    localparam logic [4:0] S_TRIS = 5'd19, S_NOP = 5'd20, S_HALT = 5'd21;

    logic        clk;
    logic        rst_n;
    logic [11:0] IR;
    logic        skipCond;
    logic        wake;
    logic [4:0]  executeState;
    logic        irLoad;
    logic        pcInc;
    logic        flushed;
    logic        sleeping;

    logic [11:0] sweepIr;
    logic [4:0]  sweepQ4;

    int assertions = 0;
    int failures   = 0;

    execute_state_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IR           (IR),
        .skipCond     (skipCond),
        .wake         (wake),
        .executeState (executeState),
        .irLoad       (irLoad),
        .pcInc        (pcInc),
        .flushed      (flushed),
        .sleeping     (sleeping)
    );

    inst_q4_decode sweepDut (
        .ir      (sweepIr),
        .q4State (sweepQ4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic tick3;
        tick(); tick(); tick();
    endtask

    // Reference classification written as address ranges of the opcode map.
    function automatic logic [4:0] refDecode(input logic [11:0] v);
        if (v == 12'h002) return S_OPTION;
        if (v == 12'h003) return S_SLEEP;
        if (v == 12'h004) return S_CLRWDT;
        if (v >= 12'h005 && v <= 12'h007) return S_TRIS;
        if (v <= 12'h01F) return S_NOP;
        if (v <= 12'h03F) return S_MOVWF;
        if (v == 12'h040) return S_CLRW;
        if (v <= 12'h05F) return S_NOP;
        if (v <= 12'h07F) return S_CLRF;
        if (v <= 12'h1FF) return S_ELSE;
        if (v <= 12'h23F) return S_MOVF;
        if (v <= 12'h2BF) return S_ELSE;
        if (v <= 12'h2FF) return S_FSZ;
        if (v <= 12'h3BF) return S_ELSE;
        if (v <= 12'h3FF) return S_FSZ;
        if (v <= 12'h5FF) return S_BXF;
        if (v <= 12'h7FF) return S_BTFSX;
        if (v <= 12'h8FF) return S_RETLW;
        if (v <= 12'h9FF) return S_CALL;
        if (v <= 12'hBFF) return S_GOTO;
        if (v <= 12'hCFF) return S_MOVLW;
        return S_ALUXLW;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; IR = 12'h000; skipCond = 1'b0; wake = 1'b0;
        tick(); tick();
        assertions++; if (executeState !== S_Q1) begin failures++; $display("FAIL reset_state: got %0d expected %0d", executeState, S_Q1); end
        assertions++; if (flushed !== 1'b1) begin failures++; $display("FAIL reset_flushed: got %b expected 1", flushed); end
        assertions++; if (sleeping !== 1'b0) begin failures++; $display("FAIL reset_sleeping: got %b expected 0", sleeping); end
        assertions++; if (irLoad !== 1'b0) begin failures++; $display("FAIL reset_irLoad: got %b expected 0", irLoad); end
        assertions++; if (pcInc !== 1'b0) begin failures++; $display("FAIL reset_pcInc: got %b expected 0", pcInc); end
        rst_n = 1'b1;
    endtask

    task automatic test_movlw;
        IR = 12'hC5A;
        tick();
        assertions++; if (executeState !== S_Q2) begin failures++; $display("FAIL movlw_q2: got %0d expected %0d", executeState, S_Q2); end
        tick();
        assertions++; if (executeState !== S_Q3) begin failures++; $display("FAIL movlw_q3: got %0d expected %0d", executeState, S_Q3); end
        tick();
        assertions++; if (executeState !== S_NOP) begin failures++; $display("FAIL first_q4_nop: got %0d expected %0d", executeState, S_NOP); end
        assertions++; if (irLoad !== 1'b1) begin failures++; $display("FAIL first_q4_irLoad: got %b expected 1", irLoad); end
        assertions++; if (flushed !== 1'b1) begin failures++; $display("FAIL first_q4_flushed: got %b expected 1", flushed); end
        tick();
        assertions++; if (executeState !== S_Q1) begin failures++; $display("FAIL movlw_q1: got %0d expected %0d", executeState, S_Q1); end
        assertions++; if (flushed !== 1'b0) begin failures++; $display("FAIL movlw_flush_clear: got %b expected 0", flushed); end
        assertions++; if (irLoad !== 1'b0) begin failures++; $display("FAIL q1_irLoad: got %b expected 0", irLoad); end
        tick3();
        assertions++; if (executeState !== S_MOVLW) begin failures++; $display("FAIL movlw_q4: got %0d expected %0d", executeState, S_MOVLW); end
        assertions++; if (irLoad !== 1'b1) begin failures++; $display("FAIL movlw_irLoad: got %b expected 1", irLoad); end
        assertions++; if (pcInc !== 1'b1) begin failures++; $display("FAIL movlw_pcInc: got %b expected 1", pcInc); end
        tick();
        assertions++; if (executeState !== S_Q1) begin failures++; $display("FAIL movlw_wrap: got %0d expected %0d", executeState, S_Q1); end
    endtask

    task automatic test_goto;
        IR = 12'hA10;
        tick3();
        assertions++; if (executeState !== S_GOTO) begin failures++; $display("FAIL goto_q4: got %0d expected %0d", executeState, S_GOTO); end
        assertions++; if (pcInc !== 1'b0) begin failures++; $display("FAIL goto_pcInc: got %b expected 0", pcInc); end
        assertions++; if (irLoad !== 1'b1) begin failures++; $display("FAIL goto_irLoad: got %b expected 1", irLoad); end
        tick();
        assertions++; if (flushed !== 1'b1) begin failures++; $display("FAIL goto_flush: got %b expected 1", flushed); end
        IR = 12'hC00;
        tick3();
        assertions++; if (executeState !== S_NOP) begin failures++; $display("FAIL goto_next_nop: got %0d expected %0d", executeState, S_NOP); end
        assertions++; if (pcInc !== 1'b1) begin failures++; $display("FAIL flushed_nop_pcInc: got %b expected 1", pcInc); end
        tick();
        assertions++; if (flushed !== 1'b0) begin failures++; $display("FAIL goto_flush_end: got %b expected 0", flushed); end
    endtask

    task automatic test_skip;
        IR = 12'h2F0; skipCond = 1'b1;
        tick3();
        assertions++; if (executeState !== S_FSZ) begin failures++; $display("FAIL decfsz_q4: got %0d expected %0d", executeState, S_FSZ); end
        tick();
        assertions++; if (flushed !== 1'b1) begin failures++; $display("FAIL decfsz_skip: got %b expected 1", flushed); end
        IR = 12'hC00; skipCond = 1'b0;
        tick3();
        assertions++; if (executeState !== S_NOP) begin failures++; $display("FAIL decfsz_skipped_nop: got %0d expected %0d", executeState, S_NOP); end
        tick();
        IR = 12'h2F0; skipCond = 1'b0;
        tick3();
        tick();
        assertions++; if (flushed !== 1'b0) begin failures++; $display("FAIL decfsz_noskip: got %b expected 0", flushed); end
        IR = 12'hC00;
        tick3();
        assertions++; if (executeState !== S_MOVLW) begin failures++; $display("FAIL decfsz_next_exec: got %0d expected %0d", executeState, S_MOVLW); end
        tick();
        // skipCond high through Q1..Q3 but low in Q4 must not skip
        IR = 12'h2F0; skipCond = 1'b1;
        tick3();
        skipCond = 1'b0;
        tick();
        assertions++; if (flushed !== 1'b0) begin failures++; $display("FAIL skip_sample_q4: got %b expected 0", flushed); end
    endtask

    task automatic test_skip_chain;
        IR = 12'h603; skipCond = 1'b1;
        tick3();
        assertions++; if (executeState !== S_BTFSX) begin failures++; $display("FAIL btfsc_q4: got %0d expected %0d", executeState, S_BTFSX); end
        tick();
        assertions++; if (flushed !== 1'b1) begin failures++; $display("FAIL btfsc_skip: got %b expected 1", flushed); end
        tick3();
        assertions++; if (executeState !== S_NOP) begin failures++; $display("FAIL chain_nop: got %0d expected %0d", executeState, S_NOP); end
        tick();
        assertions++; if (flushed !== 1'b0) begin failures++; $display("FAIL chain_no_reflush: got %b expected 0", flushed); end
        IR = 12'hC00; skipCond = 1'b0;
        tick3();
        assertions++; if (executeState !== S_MOVLW) begin failures++; $display("FAIL chain_third_exec: got %0d expected %0d", executeState, S_MOVLW); end
        tick();
    endtask

    task automatic test_sleep;
        IR = 12'h003;
        tick3();
        assertions++; if (executeState !== S_SLEEP) begin failures++; $display("FAIL sleep_q4: got %0d expected %0d", executeState, S_SLEEP); end
        tick();
        IR = 12'hC22;
        assertions++; if (executeState !== S_HALT) begin failures++; $display("FAIL sleep_halt: got %0d expected %0d", executeState, S_HALT); end
        assertions++; if (sleeping !== 1'b1) begin failures++; $display("FAIL sleep_flag: got %b expected 1", sleeping); end
        for (int i = 0; i < 10; i++) begin
            tick();
            assertions++;
            if (executeState !== S_HALT || irLoad !== 1'b0 || pcInc !== 1'b0 || sleeping !== 1'b1) begin
                failures++;
                $display("FAIL halt_hold cycle %0d: got state=%0d irLoad=%b pcInc=%b sleeping=%b expected state=%0d 0 0 1",
                         i, executeState, irLoad, pcInc, sleeping, S_HALT);
            end
        end
        wake = 1'b1;
        tick();
        wake = 1'b0;
        assertions++; if (executeState !== S_Q1) begin failures++; $display("FAIL wake_q1: got %0d expected %0d", executeState, S_Q1); end
        assertions++; if (sleeping !== 1'b0) begin failures++; $display("FAIL wake_sleeping: got %b expected 0", sleeping); end
        assertions++; if (flushed !== 1'b0) begin failures++; $display("FAIL wake_flushed: got %b expected 0", flushed); end
        tick3();
        assertions++; if (executeState !== S_MOVLW) begin failures++; $display("FAIL wake_next_q4: got %0d expected %0d", executeState, S_MOVLW); end
        tick();
    endtask

    task automatic test_wake_with_sleep;
        // wake held high throughout: ignored in Q1..Q4, halt still lasts one clock
        IR = 12'h003; wake = 1'b1;
        tick();
        assertions++; if (executeState !== S_Q2) begin failures++; $display("FAIL wake_ignored_q2: got %0d expected %0d", executeState, S_Q2); end
        tick(); tick();
        assertions++; if (executeState !== S_SLEEP) begin failures++; $display("FAIL wake_sleep_q4: got %0d expected %0d", executeState, S_SLEEP); end
        tick();
        assertions++; if (executeState !== S_HALT) begin failures++; $display("FAIL wake_min_halt: got %0d expected %0d", executeState, S_HALT); end
        tick();
        wake = 1'b0;
        assertions++; if (executeState !== S_Q1 || sleeping !== 1'b0) begin failures++; $display("FAIL wake_exit: got state=%0d sleeping=%b expected %0d 0", executeState, sleeping, S_Q1); end
    endtask

    task automatic test_reset_mid;
        IR = 12'h900;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        assertions++; if (executeState !== S_Q1) begin failures++; $display("FAIL async_reset_state: got %0d expected %0d", executeState, S_Q1); end
        assertions++; if (flushed !== 1'b1) begin failures++; $display("FAIL async_reset_flush: got %b expected 1", flushed); end
        tick();
        rst_n = 1'b1;
        tick3();
        assertions++; if (executeState !== S_NOP) begin failures++; $display("FAIL post_reset_nop: got %0d expected %0d", executeState, S_NOP); end
        tick();
        tick3();
        assertions++; if (executeState !== S_CALL) begin failures++; $display("FAIL call_q4: got %0d expected %0d", executeState, S_CALL); end
        assertions++; if (pcInc !== 1'b0) begin failures++; $display("FAIL call_pcInc: got %b expected 0", pcInc); end
        tick();
        assertions++; if (flushed !== 1'b1) begin failures++; $display("FAIL call_flush: got %b expected 1", flushed); end
        IR = 12'hC00;
        tick3();
        tick();
    endtask

    task automatic test_ir_change;
        IR = 12'hA10;
        tick();
        IR = 12'h2F0;
        tick();
        IR = 12'hC00;
        tick();
        assertions++; if (executeState !== S_MOVLW) begin failures++; $display("FAIL ir_sampled_q3: got %0d expected %0d", executeState, S_MOVLW); end
        IR = 12'hA10;
        #2;
        assertions++; if (executeState !== S_MOVLW || pcInc !== 1'b1) begin failures++; $display("FAIL ir_change_q4: got state=%0d pcInc=%b expected %0d 1", executeState, pcInc, S_MOVLW); end
        tick();
        assertions++; if (flushed !== 1'b0) begin failures++; $display("FAIL ir_change_flush: got %b expected 0", flushed); end
    endtask

    task automatic test_decode_sweep;
        int printed;
        logic [4:0] expQ4;
        printed = 0;
        for (int i = 0; i < 4096; i++) begin
            sweepIr = i[11:0];
            #1;
            expQ4 = refDecode(sweepIr);
            assertions++;
            if (sweepQ4 !== expQ4) begin
                failures++;
                if (printed < 20) begin
                    printed++;
                    $display("FAIL decode_sweep IR=%03h: got %0d expected %0d", sweepIr, sweepQ4, expQ4);
                end
            end
        end
    endtask

    initial begin
        sweepIr = 12'h000;
        test_reset();
        test_movlw();
        test_goto();
        test_skip();
        test_skip_chain();
        test_sleep();
        test_wake_with_sleep();
        test_reset_mid();
        test_ir_change();
        test_decode_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
